// File: rtl/mac_operand_sequencer.sv
// Initiator-side sequencer: feeds VEC_LEN operand pairs into a MAC, clearing it before
// each vector, then returns the accumulated dot product on a valid/ready result port.
module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    flush,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic                    busy
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    CAPTURE,
    RESULT
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    mac_en_d, mac_clr_d;
  logic [DATA_WIDTH-1:0]   mac_a_d, mac_b_d;
  logic                    res_valid_d;
  logic [3*DATA_WIDTH-1:0] res_data_d;
  logic                    handshake;

  assign in_ready  = (state_q == ACCUM);
  assign handshake = in_valid & in_ready;
  assign busy      = (state_q == CLEAR) || (state_q == ACCUM) ||
                     (state_q == DRAIN) || (state_q == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mac_en    <= mac_en_d;
      mac_clr   <= mac_clr_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
    end
  end

  // Flush overrides every transition, including a same-cycle operand handshake.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mac_en_d    = mac_en;
    mac_clr_d   = mac_clr;
    mac_a_d     = mac_a;
    mac_b_d     = mac_b;
    res_valid_d = res_valid;
    res_data_d  = res_data;

    if (flush && (state_q != IDLE)) begin
      state_d     = CLEAR;
      mac_clr_d   = 1'b1;
      mac_en_d    = 1'b0;
      res_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CLEAR;
          mac_clr_d = 1'b1;
        end
        CLEAR: begin
          mac_clr_d = 1'b0;
          count_d   = '0;
          state_d   = ACCUM;
        end
        ACCUM: begin
          if (handshake) begin
            mac_a_d  = in_a;
            mac_b_d  = in_b;
            mac_en_d = 1'b1;
            count_d  = count_q + CW'(1);
            if (count_q == LAST_IDX) begin
              state_d = DRAIN;
            end
          end else begin
            mac_en_d = 1'b0;
          end
        end
        DRAIN: begin
          mac_en_d = 1'b0;
          state_d  = CAPTURE;
        end
        // The last product landed in the MAC on the DRAIN edge, so Cout is final here.
        CAPTURE: begin
          res_data_d  = mac_cout;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            mac_clr_d   = 1'b1;
            state_d     = CLEAR;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with VEC_LEN=4 and a behavioural MAC
// attached to the sequencer's En/Clr/Ain/Bin/Cout interface.
module tb_mac_operand_sequencer;

  localparam int DW = 8;
  localparam int VL = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            flush;
  logic            mac_en;
  logic            mac_clr;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [3*DW-1:0] mac_cout;
  logic            res_valid;
  logic            res_ready;
  logic [3*DW-1:0] res_data;
  logic            busy;

  int check_count = 0;
  int fail_count  = 0;
  int en_cnt      = 0;
  int rv_cnt      = 0;
  int en_snap;
  int rv_snap;

  mac_operand_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .flush     (flush),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_cout  (mac_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural MAC: clear wins, otherwise accumulate on enable.
  logic [3*DW-1:0] mac_acc = '0;
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + mac_a * mac_b;
  end
  assign mac_cout = mac_acc;

  always @(posedge clk) begin
    if (mac_en) en_cnt++;
    if (res_valid) rv_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int i;
    for (i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
  endtask

  task automatic waitResult(input string tag, input logic [31:0] expected);
    int i;
    for (i = 0; i < 20 && !res_valid; i++) tick();
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
    checkOutput(tag, 32'(res_data), expected);
  endtask

  // Result accepted this edge: one CLEAR cycle with mac_clr, then ACCUM.
  task automatic finishVector(input string tag);
    tick();
    checkOutput({tag, "_clr"}, 32'(mac_clr), 32'd1);
    checkOutput({tag, "_clr_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_clr_rvalid"}, 32'(res_valid), 32'd0);
    tick();
    checkOutput({tag, "_acc_clr"}, 32'(mac_clr), 32'd0);
    checkOutput({tag, "_acc_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    res_ready = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_mac_en", 32'(mac_en), 32'd0);
    checkOutput("rst_mac_clr", 32'(mac_clr), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    checkOutput("idle_to_clear_clr", 32'(mac_clr), 32'd1);
    checkOutput("idle_to_clear_busy", 32'(busy), 32'd1);

    // Back-to-back vector, latency and mac_en count
    en_snap = en_cnt;
    rv_snap = rv_cnt;
    applyStimulus(8'd1, 8'd2);
    applyStimulus(8'd3, 8'd4);
    applyStimulus(8'd5, 8'd6);
    applyStimulus(8'd7, 8'd8);
    in_valid = 1'b0;
    checkOutput("t1_drain_en", 32'(mac_en), 32'd1);
    checkOutput("t1_drain_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("t1_capture_rvalid", 32'(res_valid), 32'd0);
    checkOutput("t1_capture_en", 32'(mac_en), 32'd0);
    tick();
    checkOutput("t1_result_rvalid", 32'(res_valid), 32'd1);
    checkOutput("t1_result_data", 32'(res_data), 32'd100);
    finishVector("t1");
    checkOutput("t1_en_cycles", 32'(en_cnt - en_snap), 32'd4);
    checkOutput("t1_rvalid_pulse", 32'(rv_cnt - rv_snap), 32'd1);

    // in_valid with gaps: 1-0-0-1
    en_snap = en_cnt;
    applyStimulus(8'd1, 8'd2);
    checkOutput("t2_en_hs1", 32'(mac_en), 32'd1);
    in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
    tick();
    checkOutput("t2_en_gap1", 32'(mac_en), 32'd0);
    tick();
    checkOutput("t2_en_gap2", 32'(mac_en), 32'd0);
    applyStimulus(8'd3, 8'd4);
    checkOutput("t2_en_hs2", 32'(mac_en), 32'd1);
    in_valid = 1'b0; in_a = 8'hAA;
    tick();
    tick();
    checkOutput("t2_en_gap3", 32'(mac_en), 32'd0);
    applyStimulus(8'd5, 8'd6);
    in_valid = 1'b0;
    tick();
    tick();
    applyStimulus(8'd7, 8'd8);
    in_valid = 1'b0;
    waitResult("t2_result", 32'd100);
    checkOutput("t2_en_cycles", 32'(en_cnt - en_snap), 32'd4);
    finishVector("t2");

    // Maximum operands, then minimum, each preceded by a clear
    for (int i = 0; i < VL; i++) applyStimulus(8'd255, 8'd255);
    in_valid = 1'b0;
    waitResult("t3_max", 32'd260100);
    finishVector("t3a");
    for (int i = 0; i < VL; i++) applyStimulus(8'd1, 8'd1);
    in_valid = 1'b0;
    waitResult("t3_min", 32'd4);
    finishVector("t3b");

    // Result backpressure
    res_ready = 1'b0;
    applyStimulus(8'd1, 8'd2);
    applyStimulus(8'd3, 8'd4);
    applyStimulus(8'd5, 8'd6);
    applyStimulus(8'd7, 8'd8);
    in_valid = 1'b0;
    waitResult("t4_result", 32'd100);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
      tick();
      checkOutput("t4_hold_rvalid", 32'(res_valid), 32'd1);
      checkOutput("t4_hold_data", 32'(res_data), 32'd100);
      checkOutput("t4_hold_ready", 32'(in_ready), 32'd0);
      checkOutput("t4_hold_en", 32'(mac_en), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("t4_rel_rvalid", 32'(res_valid), 32'd0);
    checkOutput("t4_rel_clr", 32'(mac_clr), 32'd1);
    checkOutput("t4_rel_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("t4_rel_accum", 32'(in_ready), 32'd1);

    // Flush mid-vector, with a simultaneous handshake attempt
    rv_snap = rv_cnt;
    applyStimulus(8'd9, 8'd9);
    applyStimulus(8'd9, 8'd9);
    flush = 1'b1;
    tick();
    checkOutput("t5_flush_clr", 32'(mac_clr), 32'd1);
    checkOutput("t5_flush_en", 32'(mac_en), 32'd0);
    checkOutput("t5_flush_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("t5_flush_hold_clr", 32'(mac_clr), 32'd1);
    checkOutput("t5_flush_hold_busy", 32'(busy), 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    checkOutput("t5_after_flush_ready", 32'(in_ready), 32'd1);
    checkOutput("t5_no_result", 32'(rv_cnt - rv_snap), 32'd0);
    for (int i = 0; i < VL; i++) applyStimulus(8'd2, 8'd2);
    in_valid = 1'b0;
    waitResult("t5_result", 32'd16);
    finishVector("t5");

    // Asynchronous reset mid-vector
    applyStimulus(8'd3, 8'd5);
    applyStimulus(8'd3, 8'd5);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_en", 32'(mac_en), 32'd0);
    checkOutput("t6_rst_a", 32'(mac_a), 32'd0);
    checkOutput("t6_rst_b", 32'(mac_b), 32'd0);
    checkOutput("t6_rst_clr", 32'(mac_clr), 32'd0);
    checkOutput("t6_rst_rvalid", 32'(res_valid), 32'd0);
    checkOutput("t6_rst_rdata", 32'(res_data), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("t6_restart_clr", 32'(mac_clr), 32'd1);
    for (int i = 0; i < VL; i++) applyStimulus(8'd3, 8'd5);
    in_valid = 1'b0;
    waitResult("t6_result", 32'd60);
    finishVector("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
